// File: rtl/timebase_gen_if.sv
// Control and strobe bundle between the timebase generator and its consumers.
// The master drives run/period/interrupt controls; the slave returns strobes, squares and the interrupt.
interface timebase_gen_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 16
);
    logic                      restart;
    logic [NUM_CH-1:0]         ch_run;
    logic [NUM_CH*DIV_W-1:0]   per;
    logic [NUM_CH-1:0]         cascade_sel;
    logic                      int_mode;
    logic                      int_ack;
    logic [NUM_CH-1:0]         en_o;
    logic [NUM_CH-1:0]         sq_o;
    logic                      int_o;

    modport master (
        output restart, ch_run, per, cascade_sel, int_mode, int_ack,
        input  en_o, sq_o, int_o
    );

    modport slave (
        input  restart, ch_run, per, cascade_sel, int_mode, int_ack,
        output en_o, sq_o, int_o
    );
endinterface

// File: rtl/timebase_gen.sv
// Multi-channel clock-enable/square-wave timebase with a divided interrupt generator.
// Define TIMEBASE_CASCADE_EN to let channel i>0 tick on the strobe of channel i-1.
module timebase_gen #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned INT_CH  = 1,
    parameter int unsigned INT_DIV = 14
) (
    input  logic           clk,
    input  logic           rst,
    timebase_gen_if.slave  bus
);
    localparam int unsigned     IC_W    = (INT_DIV > 1) ? $clog2(INT_DIV) : 1;
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(INT_DIV - 1);

    logic [DIV_W-1:0]  per_c [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] sq_q, sq_d;
    logic [NUM_CH-1:0] tick_c;
    logic [IC_W-1:0]   ic_q, ic_d;
    logic              int_q, int_d;
    logic              src_c, wrap_c;
    logic              unused_c;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            per_c[i] = bus.per[i*DIV_W +: DIV_W];
        end
    end

    // Tick source selection: free-running, or the previous channel's registered strobe.
`ifdef TIMEBASE_CASCADE_EN
    always_comb begin
        tick_c    = '1;
        for (int unsigned i = 1; i < NUM_CH; i++) begin
            tick_c[i] = bus.cascade_sel[i] ? en_q[i-1] : 1'b1;
        end
    end
    assign unused_c = bus.cascade_sel[0];
`else
    assign tick_c   = '1;
    assign unused_c = ^bus.cascade_sel;
`endif

    // Channel counters; restart wins over any tick, a stopped channel holds.
    always_comb begin
        logic [DIV_W-1:0] nxt;
        en_d = '0;
        sq_d = sq_q;
        nxt  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.restart) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
            end else if (tick_c[i] && bus.ch_run[i]) begin
                if (cnt_q[i] >= per_c[i]) begin
                    nxt     = '0;
                    en_d[i] = 1'b1;
                end else begin
                    nxt = cnt_q[i] + DIV_W'(1);
                end
                cnt_d[i] = nxt;
                sq_d[i]  = (nxt > (per_c[i] >> 1));
            end
        end
    end

    // Interrupt divider follows the strobe being issued on this edge, not the registered one.
    assign src_c  = en_d[INT_CH];
    assign wrap_c = src_c && (ic_q == IC_LAST);

    always_comb begin
        ic_d  = ic_q;
        int_d = int_q;
        if (bus.restart) begin
            ic_d  = '0;
            int_d = 1'b0;
        end else begin
            if (src_c) begin
                ic_d = (ic_q == IC_LAST) ? '0 : ic_q + IC_W'(1);
            end
            if (!bus.int_mode) begin
                int_d = (ic_d == IC_LAST);
            end else if (wrap_c) begin
                int_d = 1'b1;
            end else if (bus.int_ack) begin
                int_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            en_q  <= '0;
            sq_q  <= '0;
            ic_q  <= '0;
            int_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            en_q  <= en_d;
            sq_q  <= sq_d;
            ic_q  <= ic_d;
            int_q <= int_d;
        end
    end

    assign bus.en_o  = en_q;
    assign bus.sq_o  = sq_q;
    assign bus.int_o = int_q;
endmodule

// File: tb/tb_timebase_gen.sv
// Scoreboard bench for timebase_gen: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_timebase_gen;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DIV_W  = 16;

    typedef struct {
        int         cyc;
        logic [3:0] en_m;
        logic [3:0] en_e;
        logic [3:0] sq_m;
        logic [3:0] sq_e;
        bit         int_c;
        logic       int_e;
        string      tag;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   c0;
    int   checks;
    int   failures;
    exp_t q[$];

    timebase_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    timebase_gen #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W),
        .INT_CH (1),
        .INT_DIV(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int n, input logic [3:0] en_m, input logic [3:0] en_e,
                        input logic [3:0] sq_m, input logic [3:0] sq_e,
                        input bit int_c, input logic int_e, input string tag);
        exp_t e;
        e.cyc = c0 + n; e.en_m = en_m; e.en_e = en_e; e.sq_m = sq_m; e.sq_e = sq_e;
        e.int_c = int_c; e.int_e = int_e; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic wait_k(input int k);
        while (cyc < c0 + k) @(negedge clk);
    endtask

    task automatic set_per(input int ch, input logic [15:0] v);
        bus.per[ch*DIV_W +: DIV_W] = v;
    endtask

    task automatic do_restart();
        c0 = cyc;
        bus.restart = 1'b1;
        push(1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, "restart");
        @(negedge clk);
        bus.restart = 1'b0;
        c0 = cyc;
    endtask

    // Monitor: pop every expectation due at this cycle and compare against the DUT.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checks++; failures++;
                $display("FAIL %s late cyc=%0d got_cyc=%0d", e.tag, e.cyc, cyc);
            end else begin
                if (e.en_m != 4'h0) begin
                    checks++;
                    if ((bus.en_o & e.en_m) !== (e.en_e & e.en_m)) begin
                        failures++;
                        $display("FAIL %s en_o cyc=%0d got=%b exp=%b mask=%b",
                                 e.tag, cyc, bus.en_o, e.en_e, e.en_m);
                    end
                end
                if (e.sq_m != 4'h0) begin
                    checks++;
                    if ((bus.sq_o & e.sq_m) !== (e.sq_e & e.sq_m)) begin
                        failures++;
                        $display("FAIL %s sq_o cyc=%0d got=%b exp=%b mask=%b",
                                 e.tag, cyc, bus.sq_o, e.sq_e, e.sq_m);
                    end
                end
                if (e.int_c) begin
                    checks++;
                    if (bus.int_o !== e.int_e) begin
                        failures++;
                        $display("FAIL %s int_o cyc=%0d got=%b exp=%b",
                                 e.tag, cyc, bus.int_o, e.int_e);
                    end
                end
            end
        end
    end

    initial begin
        checks = 0; failures = 0; c0 = 0;
        rst = 1'b0;
        bus.restart = 1'b0; bus.ch_run = 4'hF; bus.cascade_sel = 4'h0;
        bus.int_mode = 1'b0; bus.int_ack = 1'b0;
        set_per(0, 16'd7); set_per(1, 16'd8191); set_per(2, 16'd4095); set_per(3, 16'd2047);
        #1 rst = 1'b1;

        // Reset state, then free-running periods from release.
        @(negedge clk);
        c0 = cyc;
        push(1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, "reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        c0 = cyc;
        for (int n = 1; n <= 16; n++) begin
            push(n, 4'b0001, 4'((n % 8) == 0), 4'b0001, 4'((n % 8) > 3), 1'b0, 1'b0, "p1_ch0");
        end
        push(2048,  4'b1000, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0, "p1_ch3");
        push(4096,  4'b1100, 4'b1100, 4'h0, 4'h0, 1'b0, 1'b0, "p1_ch2");
        push(8191,  4'b0010, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, "p1_ch1_pre");
        push(8192,  4'b1110, 4'b1110, 4'h0, 4'h0, 1'b0, 1'b0, "p1_ch1");
        push(8193,  4'b1111, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, "p1_post");
        push(16384, 4'b1111, 4'b1111, 4'h0, 4'h0, 1'b1, 1'b0, "p1_all");

        // Restart on an edge where ch0 strobe is due.
        wait_k(16391);
        do_restart();
        push(7,  4'b0011, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, "rs_pre");
        push(8,  4'b0011, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, "rs_first");
        push(16, 4'b0001, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, "rs_second");

        // per0 = 0, then 100, then lowered to 10 while cnt0 = 50.
        push(21, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, "p0_a");
        push(25, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, "p0_b");
        push(80, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, "p100_c50");
        push(81, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, "lower_wrap");
        push(82, 4'b0001, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, "lower_after");
        push(86, 4'h0, 4'h0, 4'b0001, 4'b0000, 1'b0, 1'b0, "p10_sq5");
        push(87, 4'h0, 4'h0, 4'b0001, 4'b0001, 1'b0, 1'b0, "p10_sq6");
        push(91, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0, "p10_c10");
        push(92, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, "p10_s1");
        push(103, 4'b0001, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, "p10_s2");
        wait_k(20); set_per(0, 16'd0);
        wait_k(30); set_per(0, 16'd100);
        wait_k(80); set_per(0, 16'd10);

        // Interrupt, level mode, per1 = 3.
        wait_k(105);
        set_per(0, 16'd7); set_per(1, 16'd3);
        do_restart();
        push(4,   4'b0010, 4'b0010, 4'h0, 4'h0, 1'b1, 1'b0, "i0_s1");
        push(5,   4'b0010, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, "i0_s1_off");
        push(51,  4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "i0_pre");
        push(52,  4'b0010, 4'b0010, 4'h0, 4'h0, 1'b1, 1'b1, "i0_rise");
        push(55,  4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "i0_hold");
        push(56,  4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "i0_fall");
        push(107, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "i0_pre2");
        push(108, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "i0_rise2");
        push(111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "i0_hold2");
        push(112, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "i0_fall2");

        // Interrupt, latched mode with ack, ack-vs-set collision, and switch back to level.
        wait_k(114);
        bus.int_mode = 1'b1;
        do_restart();
        push(55,  4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "i1_nolevel");
        push(56,  4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "i1_set");
        push(70,  4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "i1_held");
        push(100, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "i1_held2");
        push(101, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "i1_ack");
        push(111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "i1_idle");
        push(112, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "i1_set_wins");
        push(113, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "i1_after");
        push(121, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "i1_ack2");
        push(170, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "i1_set3");
        push(171, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "i1_to_lvl");
        wait_k(100); bus.int_ack = 1'b1;
        wait_k(101); bus.int_ack = 1'b0;
        wait_k(111); bus.int_ack = 1'b1;
        wait_k(112); bus.int_ack = 1'b0;
        wait_k(120); bus.int_ack = 1'b1;
        wait_k(121); bus.int_ack = 1'b0;
        wait_k(170); bus.int_mode = 1'b0;

        // Async reset in mid-cycle while en0 is held high.
        wait_k(175);
        set_per(0, 16'd0);
        push(180, 4'b0001, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, "pre_rst");
        wait_k(181);
        @(posedge clk);
        #2 rst = 1'b1;
        push(182, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, "async_rst");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        c0 = cyc;
        push(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, "p0_rel1");
        push(2, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, "p0_rel2");

        // Cascade selection on channel 1.
        wait_k(3);
        set_per(0, 16'd7); set_per(1, 16'd2);
        bus.cascade_sel = 4'b0010;
        do_restart();
`ifdef TIMEBASE_CASCADE_EN
        push(24, 4'b0011, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, "cas_pre");
        push(25, 4'b0011, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0, "cas_1");
        push(26, 4'b0010, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, "cas_off");
        push(48, 4'b0010, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, "cas_pre2");
        push(49, 4'b0010, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0, "cas_2");
`else
        push(3,  4'b0010, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0, "nocas_1");
        push(4,  4'b0010, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, "nocas_off");
        push(6,  4'b0010, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0, "nocas_2");
        push(24, 4'b0011, 4'b0011, 4'h0, 4'h0, 1'b0, 1'b0, "nocas_8");
        push(25, 4'b0010, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, "nocas_off2");
`endif
        wait_k(60);
        @(negedge clk);
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/timebase_gen.md
# timebase_gen

Parametrised clock-enable and interrupt timebase for the arcade core. Derives NUM_CH independent clock-enable strobes and registered square-wave levels from the single system clock, with per-channel run-time periods, plus a divided interrupt generator in pulse or latched mode. It replaces the fixed 3 MHz/6 MHz/3 kHz/24 kHz dividers and the NMI counter. It sits beside the CPU, vector generator and sound blocks and feeds their `clk_en` inputs and the CPU `NMI`.

## Interface
Parameters:
- `NUM_CH`, 4, number of divider channels (1..8).
- `DIV_W`, 16, width of each channel counter and period.
- `INT_CH`, 1, index of the channel whose strobe drives the interrupt counter.
- `INT_DIV`, 14, interrupt divide ratio in source strobes (2..256).

Ports:
- `clk` in 1: system clock, sole clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `restart` in 1: synchronous restart of all counters.
- `ch_run` in NUM_CH: per-channel run; low holds that counter.
- `per` in NUM_CH*DIV_W: per-channel period minus one; channel i uses slice [i*DIV_W +: DIV_W].
- `cascade_sel` in NUM_CH: channel i>0 ticks on strobe i-1; bit 0 ignored.
- `int_mode` in 1: 0 = level window, 1 = latched until ack.
- `int_ack` in 1: clears latched interrupt.
- `en_o` out NUM_CH: one-`clk` strobes.
- `sq_o` out NUM_CH: registered square levels.
- `int_o` out 1: interrupt request.

## Operation
- Reset (`rst` high, async): all counters 0, `en_o`=0, `sq_o`=0, `int_o`=0, interrupt counter 0.
- Tick source for channel i: every `clk`, or `en_o[i-1]` when cascaded (see Configuration).
- On a tick with `ch_run[i]`=1:
  - if `cnt_i >= per_i`: `cnt_i`<=0, `en_o[i]`<=1.
  - else `cnt_i`<=`cnt_i`+1.
- `en_o[i]` is 0 in every cycle not described above.
- `sq_o[i]` <= (next `cnt_i` > (`per_i`>>1)). It is updated every `clk` and held when not ticking.
- `per_i`=0: strobe on every tick, so `en_o` stays high continuously for a free-running channel; `sq_o`=0.
- Lowering `per_i` below the current count gives a wrap plus strobe on the next tick; no skip, no hang.
- `ch_run[i]`=0: counter and `sq_o[i]` hold, `en_o[i]`=0.
- `restart`: all channel counters and the interrupt counter go to 0, `en_o`=0, `int_o`=0. It overrides any tick in the same cycle.
- Interrupt counter `ic` has width clog2(INT_DIV). It advances on each `en_o[INT_CH]` and wraps from INT_DIV-1 to 0.
- Mode 0: `int_o` <= (`ic_next` == INT_DIV-1). This holds `int_o` high for exactly one source period.
- Mode 1:
  - `int_o` is set on the wrap of `ic`.
  - `int_o` is cleared by `int_ack`.
  - If set and ack occur in the same cycle, set wins.
- Changing `int_mode` takes effect next cycle. Switching to 0 drops any latched request unless the level condition holds.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Strobe latency: with `per_i`=P, free-running from reset release, the first `en_o[i]` is high in the cycle after the (P+1)th rising edge. The period is exactly P+1 cycles.
- `per` changes are sampled every cycle and affect the compare on the same edge.
- An interrupt source strobe at edge n updates `int_o` at edge n.
- `int_ack` clears `int_o` at the next edge.
- `rst` deassertion is not synchronised internally. The integrator supplies a synchronised release, as done at top level.

## Configuration
- `TIMEBASE_CASCADE_EN` defined: channel i>0 with `cascade_sel[i]`=1 ticks only on cycles where `en_o[i-1]`=1.
  - Cascaded period = (per_{i-1}+1)*(per_i+1).
  - There is a one-cycle phase lag per stage.
- `TIMEBASE_CASCADE_EN` undefined: `cascade_sel` is ignored and all channels tick every `clk`. This saves the per-channel muxes.

## Test plan
- Reset, then `per`={7,8191,4095,2047}, all run: `en_o[0]` every 8 cycles, first at edge 8; `en_o[1]` every 8192; `sq_o[0]` high for counts 4..7.
- `per_0`=0: `en_o[0]` constantly 1; `sq_o[0]`=0. Set `per_0` 100→10 while `cnt_0`=50: strobe on next edge, then every 11 cycles.
- INT_CH=1, INT_DIV=14, mode 0, `per_1`=3: `int_o` high for 4 cycles once per 56 cycles, starting 52 cycles after release.
- Mode 1: `int_o` stays high until `int_ack`. Ack coincident with the next wrap leaves `int_o`=1.
- `restart` asserted on the same edge a strobe is due: no strobe, counters 0, and the next strobe is P+1 cycles after restart drops. Async `rst` mid-count zeroes all outputs without waiting for a clock.
- With `TIMEBASE_CASCADE_EN`, `per_0`=7, `per_1`=2, `cascade_sel[1]`=1: `en_o[1]` every 24 cycles. Without the macro, `en_o[1]` comes every 3 cycles.
